// File: rtl/beta_pkg.sv
// Shared types and constants for the Beta pipeline stages.
package beta_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_PC4  = 2'd2
    } res_sel_t;

    typedef enum logic {
        WB_RUN       = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    // R31 reads as zero, so writes to it are dropped.
    localparam int unsigned ZERO_REG_IDX = 31;

endpackage

// File: rtl/wb_load_timer.sv
// Wait counter for memory responses. It is cleared, counts while enabled, and
// flags expiry LOAD_TIMEOUT cycles after the owning request entered its stage.
module wb_load_timer #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOAD_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_expired;

    // The entry cycle is counted by the owner, so expiry is one short of LOAD_TIMEOUT.
    assign w_expired = (r_cnt == LAST);
    assign o_expired = w_expired;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/write_back.sv
// Beta WB stage: holds the instruction leaving MEM, waits for load data,
// selects the result and drives the register-file write port and bypass.
module write_back
    import beta_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RF_ADDR_W    = 6,
    parameter int unsigned ZERO_REG     = ZERO_REG_IDX,
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic [1:0]           mem_res_sel,
    input  logic [XLEN-1:0]      mem_alu_result,
    input  logic [XLEN-1:0]      mem_pc_plus_four,
    input  logic [RF_ADDR_W-1:0] mem_rc,
    input  logic                 mem_rf_we,
    input  logic [XLEN-1:0]      dmem_rdata,
    input  logic                 dmem_rvalid,
    output logic                 wb_stall,
    output logic [RF_ADDR_W-1:0] rf_w_addr,
    output logic [XLEN-1:0]      rf_w_data,
    output logic                 rf_we,
    output logic [XLEN-1:0]      wb_bypass,
    output logic [RF_ADDR_W-1:0] wb_bypass_rc,
    output logic                 wb_bypass_valid,
    output logic                 load_err,
    output logic [31:0]          instret
);

    logic                 r_valid;
    logic [1:0]           r_sel;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_pc4;
    logic [RF_ADDR_W-1:0] r_rc;
    logic                 r_we;
    wb_state_t            r_state;
    logic [31:0]          r_instret;

    wb_state_t            w_next_state;
    logic                 w_stall;
    logic                 w_complete;
    logic                 w_load_err;
    logic                 w_timer_en;
    logic                 w_timer_clr;
    logic                 w_expired;
    logic                 w_is_load;
    logic [XLEN-1:0]      w_load_data;
    logic [XLEN-1:0]      w_result;
    logic                 w_rf_we;

    wb_load_timer #(
        .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_timer_clr),
        .i_en     (w_timer_en),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sel   <= RES_ALU;
            r_alu   <= '0;
            r_pc4   <= '0;
            r_rc    <= '0;
            r_we    <= 1'b0;
        end else if (!w_stall) begin
            r_valid <= mem_valid;
            r_sel   <= mem_res_sel;
            r_alu   <= mem_alu_result;
            r_pc4   <= mem_pc_plus_four;
            r_rc    <= mem_rc;
            r_we    <= mem_rf_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WB_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_is_load   = (r_sel == RES_LOAD);
    assign w_timer_clr = (r_state == WB_RUN);

    // Gating with rst keeps outputs quiet during reset, even mid-wait.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_complete   = 1'b0;
        w_load_err   = 1'b0;
        w_timer_en   = 1'b0;
        w_load_data  = dmem_rdata;
        if (!rst && r_valid) begin
            case (r_state)
                WB_RUN: begin
                    if (!w_is_load || dmem_rvalid) begin
                        w_complete = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_next_state = WB_WAIT_LOAD;
                    end
                end
                WB_WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        w_complete   = 1'b1;
                        w_next_state = WB_RUN;
                    end else if (w_expired) begin
                        w_complete   = 1'b1;
                        w_load_err   = 1'b1;
                        w_load_data  = '0;
                        w_next_state = WB_RUN;
                    end else begin
                        w_stall    = 1'b1;
                        w_timer_en = 1'b1;
                    end
                end
                default: w_next_state = WB_RUN;
            endcase
        end
    end

    always_comb begin
        case (r_sel)
            RES_LOAD: w_result = w_load_data;
            RES_PC4:  w_result = r_pc4;
            default:  w_result = r_alu;
        endcase
    end

    assign w_rf_we = w_complete && r_we && (r_rc != RF_ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_complete) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign wb_stall        = w_stall;
    assign rf_w_addr       = r_rc;
    assign rf_w_data       = w_result;
    assign rf_we           = w_rf_we;
    assign wb_bypass       = w_result;
    assign wb_bypass_rc    = r_rc;
    assign wb_bypass_valid = w_rf_we;
    assign load_err        = w_load_err;
    assign instret         = r_instret;

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: cycle-level reference model plus literal checks.
module tb_write_back;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [1:0]  mem_res_sel;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_pc_plus_four;
    logic [5:0]  mem_rc;
    logic        mem_rf_we;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        wb_stall;
    logic [5:0]  rf_w_addr;
    logic [31:0] rf_w_data;
    logic        rf_we;
    logic [31:0] wb_bypass;
    logic [5:0]  wb_bypass_rc;
    logic        wb_bypass_valid;
    logic        load_err;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    write_back #(.XLEN(32), .RF_ADDR_W(6), .ZERO_REG(31), .LOAD_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_res_sel(mem_res_sel),
        .mem_alu_result(mem_alu_result), .mem_pc_plus_four(mem_pc_plus_four),
        .mem_rc(mem_rc), .mem_rf_we(mem_rf_we), .dmem_rdata(dmem_rdata),
        .dmem_rvalid(dmem_rvalid), .wb_stall(wb_stall), .rf_w_addr(rf_w_addr),
        .rf_w_data(rf_w_data), .rf_we(rf_we), .wb_bypass(wb_bypass),
        .wb_bypass_rc(wb_bypass_rc), .wb_bypass_valid(wb_bypass_valid),
        .load_err(load_err), .instret(instret)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction in WB and how many cycles it has sat there.
    logic        m_valid = 1'b0;
    logic [1:0]  m_sel;
    logic [31:0] m_alu, m_pc4;
    logic [5:0]  m_rc;
    logic        m_we;
    int          m_k = 0;
    logic [31:0] m_instret = 0;

    function automatic void expect_now(output logic st, output logic cmp,
                                       output logic err, output logic [31:0] data);
        st = 0; cmp = 0; err = 0; data = 0;
        if (rst || !m_valid) return;
        if (m_sel != 2'd1) begin
            cmp  = 1;
            data = (m_sel == 2'd2) ? m_pc4 : m_alu;
        end else if (dmem_rvalid) begin
            cmp = 1; data = dmem_rdata;
        end else if (m_k >= TO) begin
            cmp = 1; err = 1; data = 0;
        end else begin
            st = 1;
        end
    endfunction

    always @(posedge clk) begin
        logic st, cmp, err;
        logic [31:0] d;
        expect_now(st, cmp, err, d);
        if (rst) begin
            m_valid   = 0;
            m_k       = 0;
            m_instret = 0;
        end else begin
            if (cmp) m_instret = m_instret + 1;
            if (!st) begin
                m_valid = mem_valid; m_sel = mem_res_sel; m_alu = mem_alu_result;
                m_pc4 = mem_pc_plus_four; m_rc = mem_rc; m_we = mem_rf_we; m_k = 0;
            end else begin
                m_k++;
            end
        end
    end

    always @(negedge clk) begin
        logic st, cmp, err, we;
        logic [31:0] d;
        expect_now(st, cmp, err, d);
        we = cmp && m_we && (m_rc != 6'd31);
        chk("m_stall", {31'd0, wb_stall}, {31'd0, st});
        chk("m_rf_we", {31'd0, rf_we}, {31'd0, we});
        chk("m_bypass_valid", {31'd0, wb_bypass_valid}, {31'd0, we});
        chk("m_load_err", {31'd0, load_err}, {31'd0, err});
        chk("m_instret", instret, m_instret);
        chk("m_data_known", {31'd0, $isunknown(rf_w_data)}, 32'd0);
        if (we) begin
            chk("m_w_addr", {26'd0, rf_w_addr}, {26'd0, m_rc});
            chk("m_w_data", rf_w_data, d);
            chk("m_bypass", wb_bypass, d);
            chk("m_bypass_rc", {26'd0, wb_bypass_rc}, {26'd0, m_rc});
        end
    end

    task automatic mem_in(input logic v, input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [5:0] rc, input logic we);
        mem_valid = v; mem_res_sel = sel; mem_alu_result = alu;
        mem_pc_plus_four = pc4; mem_rc = rc; mem_rf_we = we;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; dmem_rvalid = 0; dmem_rdata = 0;
        mem_in(0, 2'd0, 0, 0, 0, 0);
        repeat (3) nxt();
        smp();
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_stall", {31'd0, wb_stall}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        rst = 0;
        nxt();

        // ALU write
        mem_in(1, 2'd0, 32'h1234, 32'h4, 6'd5, 1);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        smp();
        chk("alu_we", {31'd0, rf_we}, 32'd1);
        chk("alu_addr", {26'd0, rf_w_addr}, 32'd5);
        chk("alu_data", rf_w_data, 32'h1234);
        chk("alu_bpv", {31'd0, wb_bypass_valid}, 32'd1);
        nxt();
        smp();
        chk("alu_instret", instret, 32'd1);

        // load answered 3 cycles after entry, ALU op queued behind it
        mem_in(1, 2'd1, 32'h40, 32'h8, 6'd7, 1);
        nxt();
        mem_in(1, 2'd0, 32'h88, 32'hC, 6'd8, 1);
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("ld_stall", {31'd0, wb_stall}, 32'd1);
            chk("ld_no_we", {31'd0, rf_we}, 32'd0);
            nxt();
        end
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        smp();
        chk("ld_stall_end", {31'd0, wb_stall}, 32'd0);
        chk("ld_data", rf_w_data, 32'hDEADBEEF);
        chk("ld_addr", {26'd0, rf_w_addr}, 32'd7);
        nxt();
        dmem_rvalid = 0; mem_in(0, 2'd0, 0, 0, 0, 0);
        smp();
        chk("held_we", {31'd0, rf_we}, 32'd1);
        chk("held_addr", {26'd0, rf_w_addr}, 32'd8);
        chk("held_data", rf_w_data, 32'h88);
        nxt();

        // same-cycle load response, then a stray response
        mem_in(1, 2'd1, 32'h50, 32'h10, 6'd9, 1);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        dmem_rvalid = 1; dmem_rdata = 32'hA5A5A5A5;
        smp();
        chk("fast_stall", {31'd0, wb_stall}, 32'd0);
        chk("fast_data", rf_w_data, 32'hA5A5A5A5);
        nxt();
        smp();
        chk("stray_we", {31'd0, rf_we}, 32'd0);
        nxt();
        dmem_rvalid = 0;

        // PC4 to R31 and R28
        mem_in(1, 2'd2, 32'h55, 32'h100, 6'd31, 1);
        nxt();
        mem_in(1, 2'd2, 32'h55, 32'h100, 6'd28, 1);
        smp();
        chk("r31_we", {31'd0, rf_we}, 32'd0);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        smp();
        chk("pc4_data", rf_w_data, 32'h100);
        chk("pc4_addr", {26'd0, rf_w_addr}, 32'd28);
        nxt();
        smp();
        chk("pc4_instret", instret, 32'd6);

        // load timeout
        mem_in(1, 2'd1, 32'h60, 32'h14, 6'd10, 1);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        for (int i = 0; i < TO; i++) begin
            smp();
            chk("to_stall", {31'd0, wb_stall}, 32'd1);
            chk("to_err_lo", {31'd0, load_err}, 32'd0);
            nxt();
        end
        smp();
        chk("to_err", {31'd0, load_err}, 32'd1);
        chk("to_we", {31'd0, rf_we}, 32'd1);
        chk("to_data", rf_w_data, 32'd0);
        chk("to_stall_end", {31'd0, wb_stall}, 32'd0);
        nxt();
        smp();
        chk("to_err_pulse", {31'd0, load_err}, 32'd0);
        chk("to_instret", instret, 32'd7);
        nxt();

        // reset during a load wait
        mem_in(1, 2'd1, 32'h70, 32'h18, 6'd11, 1);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        nxt();
        rst = 1;
        nxt();
        smp();
        chk("rw_stall", {31'd0, wb_stall}, 32'd0);
        chk("rw_instret", instret, 32'd0);
        rst = 0;
        nxt();
        dmem_rvalid = 1; dmem_rdata = 32'h77;
        smp();
        chk("rw_we", {31'd0, rf_we}, 32'd0);
        chk("rw_stall2", {31'd0, wb_stall}, 32'd0);
        nxt();
        dmem_rvalid = 0;

        // reserved select behaves as ALU
        mem_in(1, 2'd3, 32'hCAFE, 32'h1C, 6'd12, 1);
        nxt();
        mem_in(0, 2'd0, 0, 0, 0, 0);
        smp();
        chk("rsv_data", rf_w_data, 32'hCAFE);
        nxt();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
